mini_alu_core: RTL and testbench
================================

// Module: mini_alu_core
// PURPOSE
// - Parametrised successor of the 16-bit MiniAlu sequencer: fetch, decode-register, execute.
// - Register file is internal; instruction ROM is external.
// - Adds a multi-cycle shift-add multiplier with pipeline stall, writing the full 2*DATA_W product.
// - Adds a signed compare-branch, an illegal-opcode flag, and width/depth parameters.
// PARAMETERS
// DATA_W   16  datapath / register width (>=8)
// ADDR_W   8   register-address field width; regfile depth 2**ADDR_W
// IP_W     16  instruction-pointer width
// LED_W    8   LED latch width (<=DATA_W)
// PORTS
// Clock        in   1               rising-edge clock
// Reset        in   1               synchronous, active-low reset
// oIAddress    out  IP_W            instruction address to external ROM (combinational read)
// iInstruction in   4+3*ADDR_W      {opc[4], dst[ADDR_W], src1[ADDR_W], src0[ADDR_W]}
// oLed         out  LED_W           LED latch
// oBusy        out  1               high while multiplier owns the pipeline (stall)
// oIllegal     out  1               one-cycle pulse when executing an undefined opcode
// BEHAVIOUR
// - Reset (Reset==0 at edge): IP=0, decode reg=NOP, state=EXEC, oLed=0, oBusy=0, oIllegal=0.
//   Regfile contents untouched. Reset mid-multiply aborts; no write of either half.
// - Fetch: oIAddress=IP. Decode reg latches iInstruction each edge unless stalled.
//   Regfile reads are synchronous, addressed by the fetched src0/src1, so D0/D1 are valid in execute.
// - Regfile: 2 read ports, 1 write port; write-first bypass when read addr == write addr in same cycle.
// - Execute (one instruction per cycle in EXEC). Opcodes are unsigned; D1=src1 data, D0=src0 data:
//   NOP 0 no effect | ADD 1 R[dst]=D1+D0 | SUB 2 R[dst]=D1-D0 (both mod 2**DATA_W)
//   STO 3 R[dst]={src1,src0} zero-extended/truncated to DATA_W
//   BLE 4 branch if D1<=D0 unsigned | BLES 9 branch if D1<=D0 two's complement
//   JMP 5 branch always | LED 6 oLed<=D1[LED_W-1:0]
//   UMUL 8 / SMUL 7 start multiply, R[dst]=P[DATA_W-1:0], R[dst+1 mod depth]=P[2*DATA_W-1:DATA_W]
//   10..15 treated as NOP, oIllegal=1 for that cycle.
// - Branch: target = dst zero-extended to IP_W. oIAddress=target combinationally in the same cycle.
//   Next IP = target+1. No delay slot; the sequential instruction is discarded.
// - IP increments by 1 per unstalled cycle, wrapping 2**IP_W-1 -> 0.
// - FSM: EXEC -> MUL on UMUL/SMUL; operands captured at entry.
//   MUL: DATA_W cycles of shift-add (SMUL: operands made magnitude, product negated if signs differ).
//   Last MUL cycle writes low half -> WRHI. WRHI writes high half -> EXEC.
// - Multiply latency: DATA_W+1 stall cycles after the issue cycle. oBusy=1 in MUL and WRHI.
// - Stall: IP and decode reg hold; regfile re-reads the held fetch addresses (bypass covers WRHI).
// - No other write occurs while stalled. Branch/LED never coincide with a multiply.
// STRUCTURE
// - Shared include mini_alu_defs.vh: opcode constants (NOP..BLES), field-slice macros,
//   FSM state encodings (EXEC/MUL/WRHI).
// - Sub-module seq_mult_unit (params DATA_W):
//   start, signed_mode -> done pulse + 2*DATA_W product; the core owns the FSM and regfile write mux.
// - Regfile and decode register are inline; reuse FFD_POSEDGE_SYNCRONOUS_RESET for the decode reg
//   and LED latch with an active-low wrapper.
// TESTING
// 1 Reset held 3 cycles, released -> oIAddress 0,1,2...; oLed=0; oBusy=0; no regfile writes.
// 2 STO R1=7; STO R2=5; ADD R3=R1+R2; SUB R4=R2-R1; LED R3 -> oLed=0x0C; R4=0xFFFE.
// 3 STO R1=3, R2=0xFFFE; BLE->20 on (R1,R2): taken (3<=0xFFFE); BLES on same: not taken (3>-2).
//   On taken branch, the instruction after the branch never executes.
// 4 STO R1=0xFFFD(-3), R2=7; SMUL dst=R5 -> oBusy high 17 cycles; R5=0xFFEB, R6=0xFFFF.
//   UMUL 0xFFFF*0xFFFF -> low 0x0001, high 0xFFFE.
// 5 Assert Reset at MUL cycle 8 -> R5/R6 unchanged; IP=0; oBusy=0 next cycle.
// 6 Opcode 0xC -> oIllegal one-cycle pulse, no write, IP advances.
//   JMP from 0xFFFF wrap test: IP 0xFFFF -> 0x0000.
//   Back-to-back ADD R1=R1+R1 x3 from R1=1 -> R1=8 (bypass).

Source files
------------

// File: rtl/mini_alu_core_pkg.sv
// mini_alu_core_pkg
//   Shared definitions for the mini ALU sequencer: opcode values, the
//   execution FSM state type and small opcode-classification helpers.
//   Imported by mini_alu_core and seq_mult_unit.
package mini_alu_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_BLE  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_LED  = 4'd6;
    localparam logic [3:0] OP_SMUL = 4'd7;
    localparam logic [3:0] OP_UMUL = 4'd8;
    localparam logic [3:0] OP_BLES = 4'd9;

    // EXEC: one instruction per cycle. MUL: shift-add iterations.
    // WRHI: write the upper product half, then resume.
    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_MUL  = 2'd1,
        ST_WRHI = 2'd2
    } coreState_t;

    function automatic logic isMulOp(input logic [3:0] opc);
        return (opc == OP_UMUL) || (opc == OP_SMUL);
    endfunction

    // Everything above the last defined opcode is undefined.
    function automatic logic isIllegalOp(input logic [3:0] opc);
        return opc > OP_BLES;
    endfunction

endpackage

// File: rtl/mini_alu_core_mult.sv
// seq_mult_unit
//   Sequential shift-add multiplier, one partial product per clock.
//   Ports:
//     Clock       rising-edge clock
//     Reset       synchronous active-low reset (aborts a running multiply)
//     start       capture opA/opB and begin (single-cycle pulse)
//     signedMode  1: two's complement operands, 0: unsigned
//     opA, opB    DATA_W-bit operands
//     done        high during the final iteration cycle
//     product     2*DATA_W-bit result, valid while done is high
module seq_mult_unit
    import mini_alu_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  signedMode,
    input  logic [DATA_W-1:0]     opA,
    input  logic [DATA_W-1:0]     opB,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic              busyReg;
    logic [CNT_W-1:0]  cntReg;
    logic [DATA_W-1:0] mcandReg;
    logic [DATA_W-1:0] accHiReg;
    logic [DATA_W-1:0] accLoReg;
    logic              negReg;

    logic [DATA_W-1:0]   magA;
    logic [DATA_W-1:0]   magB;
    logic [DATA_W:0]     stepSum;
    logic [DATA_W-1:0]   stepHi;
    logic [DATA_W-1:0]   stepLo;
    logic [2*DATA_W-1:0] magProd;

    // Signed multiply runs on magnitudes; the most negative value's
    // magnitude still fits in DATA_W unsigned bits.
    assign magA = (signedMode && opA[DATA_W-1]) ? -opA : opA;
    assign magB = (signedMode && opB[DATA_W-1]) ? -opB : opB;

    // One iteration: conditionally add the multiplicand to the upper half,
    // then shift {carry, hi, lo} right by one.
    assign stepSum = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, mcandReg} : '0);
    assign stepHi  = stepSum[DATA_W:1];
    assign stepLo  = {stepSum[0], accLoReg[DATA_W-1:1]};
    assign magProd = {stepHi, stepLo};

    // The last iteration's result is presented combinationally so the core
    // can write the low half in the same cycle.
    assign done    = busyReg && (cntReg == CNT_W'(DATA_W - 1));
    assign product = negReg ? -magProd : magProd;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            busyReg <= 1'b0;
            cntReg  <= '0;
        end else if (start) begin
            busyReg <= 1'b1;
            cntReg  <= '0;
        end else if (busyReg) begin
            cntReg <= cntReg + 1'b1;
            if (done) begin
                busyReg <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (start) begin
            mcandReg <= magA;
            accHiReg <= '0;
            accLoReg <= magB;
            negReg   <= signedMode && (opA[DATA_W-1] ^ opB[DATA_W-1]);
        end else if (busyReg) begin
            accHiReg <= stepHi;
            accLoReg <= stepLo;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core
//   Two-stage (fetch / execute) sequencer with internal register file and
//   a stalling sequential multiplier.
//   Ports:
//     Clock         rising-edge clock
//     Reset         synchronous active-low reset
//     oIAddress     instruction address to external ROM (combinational read)
//     iInstruction  {opc[4], dst, src1, src0} from ROM
//     oLed          LED latch
//     oBusy         high while the multiplier stalls the pipeline
//     oIllegal      high for the execute cycle of an undefined opcode
module mini_alu_core
    import mini_alu_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [IP_W-1:0]        oIAddress,
    input  logic [4+3*ADDR_W-1:0]  iInstruction,
    output logic [LED_W-1:0]       oLed,
    output logic                   oBusy,
    output logic                   oIllegal
);
    localparam int INSTR_W = 4 + 3*ADDR_W;
    localparam int DEPTH   = 2**ADDR_W;

    coreState_t         stateReg, stateNext;
    logic [IP_W-1:0]    ipReg, ipNext;
    logic [INSTR_W-1:0] decodeReg;
    logic [LED_W-1:0]   ledReg;
    logic [ADDR_W-1:0]  mulDstReg;
    logic [DATA_W-1:0]  hiHoldReg;

    logic [3:0]        opc;
    logic [ADDR_W-1:0] dst, src1, src0;
    logic              execValid;
    logic              branchTaken;
    logic [IP_W-1:0]   target;
    logic [DATA_W-1:0] d0, d1;

    logic                wrEn;
    logic [ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]   wrData;
    logic                multStart;
    logic                multDone;
    logic [2*DATA_W-1:0] multProduct;

    logic [DATA_W-1:0] regMem [DEPTH];
    logic [ADDR_W-1:0] rdAddr [2];
    logic [DATA_W-1:0] rdData [2];

    assign opc  = decodeReg[INSTR_W-1 -: 4];
    assign dst  = decodeReg[3*ADDR_W-1 -: ADDR_W];
    assign src1 = decodeReg[2*ADDR_W-1 -: ADDR_W];
    assign src0 = decodeReg[ADDR_W-1:0];

    assign execValid = (stateReg == ST_EXEC);
    assign d0 = rdData[0];
    assign d1 = rdData[1];

    // Register file: port 0 reads src0, port 1 reads src1. While stalled the
    // held instruction's own sources are re-read so its operands see the
    // multiplier's writes (WRHI goes through the bypass).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gReadPort
            logic [DATA_W-1:0] rdQReg;

            assign rdAddr[gi] = execValid ? iInstruction[gi*ADDR_W +: ADDR_W]
                                          : decodeReg[gi*ADDR_W +: ADDR_W];

            always_ff @(posedge Clock) begin
                if (wrEn && (wrAddr == rdAddr[gi])) begin
                    rdQReg <= wrData;
                end else begin
                    rdQReg <= regMem[rdAddr[gi]];
                end
            end

            assign rdData[gi] = rdQReg;
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (wrEn) begin
            regMem[wrAddr] <= wrData;
        end
    end

    // Branch resolves in execute and redirects the fetch in the same cycle,
    // so the sequential instruction is never latched.
    assign target      = IP_W'(dst);
    assign branchTaken = execValid &&
                         ((opc == OP_JMP) ||
                          ((opc == OP_BLE)  && (d1 <= d0)) ||
                          ((opc == OP_BLES) && ($signed(d1) <= $signed(d0))));
    assign oIAddress   = branchTaken ? target : ipReg;
    assign ipNext      = execValid ? (oIAddress + IP_W'(1)) : ipReg;

    assign multStart = execValid && isMulOp(opc);

    seq_mult_unit #(
        .DATA_W (DATA_W)
    ) uMult (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (multStart),
        .signedMode (opc == OP_SMUL),
        .opA        (d1),
        .opB        (d0),
        .done       (multDone),
        .product    (multProduct)
    );

    // Single write port; nothing is written while reset is asserted, which
    // is also what makes a reset mid-multiply drop both halves.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = dst;
        wrData = d1 + d0;
        unique case (stateReg)
            ST_EXEC: begin
                unique case (opc)
                    OP_ADD: begin
                        wrEn   = 1'b1;
                        wrData = d1 + d0;
                    end
                    OP_SUB: begin
                        wrEn   = 1'b1;
                        wrData = d1 - d0;
                    end
                    OP_STO: begin
                        wrEn   = 1'b1;
                        wrData = DATA_W'({src1, src0});
                    end
                    default: ;
                endcase
            end
            ST_MUL: begin
                wrEn   = multDone;
                wrAddr = mulDstReg;
                wrData = multProduct[DATA_W-1:0];
            end
            ST_WRHI: begin
                wrEn   = 1'b1;
                wrAddr = mulDstReg + 1'b1;
                wrData = hiHoldReg;
            end
            default: ;
        endcase
        wrEn = wrEn && Reset;
    end

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            ST_EXEC: if (isMulOp(opc)) stateNext = ST_MUL;
            ST_MUL:  if (multDone)     stateNext = ST_WRHI;
            ST_WRHI:                   stateNext = ST_EXEC;
            default:                   stateNext = ST_EXEC;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stateReg  <= ST_EXEC;
            ipReg     <= '0;
            decodeReg <= '0;
            ledReg    <= '0;
        end else begin
            stateReg <= stateNext;
            ipReg    <= ipNext;
            if (execValid) begin
                decodeReg <= iInstruction;
            end
            if (execValid && (opc == OP_LED)) begin
                ledReg <= d1[LED_W-1:0];
            end
        end
    end

    // Destination captured at issue; upper half held for the WRHI cycle.
    always_ff @(posedge Clock) begin
        if (multStart) begin
            mulDstReg <= dst;
        end
        if (multDone) begin
            hiHoldReg <= multProduct[2*DATA_W-1:DATA_W];
        end
    end

    assign oLed     = ledReg;
    assign oBusy    = !execValid;
    assign oIllegal = execValid && isIllegalOp(opc);

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;

    logic        Clock;
    logic        Reset;
    logic [15:0] oIAddress;
    logic [27:0] iInstruction;
    logic [15:0] oLed;
    logic        oBusy;
    logic        oIllegal;

    logic [27:0] rom [65536];

    int total = 0;
    int bad   = 0;

    mini_alu_core #(
        .DATA_W (16),
        .ADDR_W (8),
        .IP_W   (16),
        .LED_W  (16)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oIAddress    (oIAddress),
        .iInstruction (iInstruction),
        .oLed         (oLed),
        .oBusy        (oBusy),
        .oIllegal     (oIllegal)
    );

    assign iInstruction = rom[oIAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic clearRom();
        for (int a = 0; a < 65536; a++) rom[a] = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic doReset();
        Reset = 1'b0;
        step(3);
        Reset = 1'b1;
    endtask

    task automatic waitBusy(output int busyCycles, output bit timedOut);
        bit seen;
        busyCycles = 0;
        timedOut   = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge Clock);
            #1;
            if (oBusy) begin
                busyCycles++;
                seen = 1'b1;
            end else if (seen) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clearRom();
        Reset = 1'b0;
        step(3);
        total++;
        if (oIAddress !== 16'h0000 || oBusy !== 1'b0 || oLed !== 16'h0000 || oIllegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: addr=%h busy=%b led=%h ill=%b required 0000 0 0000 0",
                     oIAddress, oBusy, oLed, oIllegal);
        end else $display("ok reset_state addr=%h busy=%b led=%h", oIAddress, oBusy, oLed);
        Reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            total++;
            if (oIAddress !== 16'(i)) begin
                bad++;
                $display("FAIL reset_ip_seq: got %h required %h", oIAddress, 16'(i));
            end else $display("ok reset_ip_seq addr=%h", oIAddress);
        end
    endtask

    task automatic test_arith();
        clearRom();
        rom[0] = mk(4'd3, 8'd1, 8'h00, 8'h07);
        rom[1] = mk(4'd3, 8'd2, 8'h00, 8'h05);
        rom[2] = mk(4'd1, 8'd3, 8'd1, 8'd2);
        rom[3] = mk(4'd2, 8'd4, 8'd2, 8'd1);
        rom[4] = mk(4'd6, 8'd0, 8'd3, 8'd0);
        rom[5] = mk(4'd6, 8'd0, 8'd4, 8'd0);
        rom[6] = mk(4'd5, 8'd6, 8'd0, 8'd0);
        doReset();
        step(6);
        total++;
        if (oLed !== 16'h000C) begin
            bad++;
            $display("FAIL arith_add_led: got %h required 000c", oLed);
        end else $display("ok arith_add_led led=%h", oLed);
        step(1);
        total++;
        if (oLed !== 16'hFFFE) begin
            bad++;
            $display("FAIL arith_sub_led: got %h required fffe", oLed);
        end else $display("ok arith_sub_led led=%h", oLed);
    endtask

    task automatic test_branch();
        clearRom();
        rom[0]  = mk(4'd3, 8'd1, 8'h00, 8'h03);
        rom[1]  = mk(4'd3, 8'd2, 8'hFF, 8'hFE);
        rom[2]  = mk(4'd4, 8'd20, 8'd1, 8'd2);
        rom[3]  = mk(4'd6, 8'd0, 8'd1, 8'd0);
        rom[20] = mk(4'd9, 8'd40, 8'd1, 8'd2);
        rom[21] = mk(4'd6, 8'd0, 8'd2, 8'd0);
        rom[22] = mk(4'd5, 8'd22, 8'd0, 8'd0);
        rom[40] = mk(4'd6, 8'd0, 8'd1, 8'd0);
        rom[41] = mk(4'd5, 8'd41, 8'd0, 8'd0);
        doReset();
        step(3);
        total++;
        if (oIAddress !== 16'd20) begin
            bad++;
            $display("FAIL ble_taken_addr: got %h required 0014", oIAddress);
        end else $display("ok ble_taken_addr addr=%h", oIAddress);
        step(1);
        total++;
        if (oIAddress !== 16'd21) begin
            bad++;
            $display("FAIL bles_not_taken_addr: got %h required 0015", oIAddress);
        end else $display("ok bles_not_taken_addr addr=%h", oIAddress);
        step(1);
        total++;
        if (oLed !== 16'h0000) begin
            bad++;
            $display("FAIL branch_no_slot: got %h required 0000", oLed);
        end else $display("ok branch_no_slot led=%h", oLed);
        step(1);
        total++;
        if (oLed !== 16'hFFFE) begin
            bad++;
            $display("FAIL branch_fallthru_led: got %h required fffe", oLed);
        end else $display("ok branch_fallthru_led led=%h", oLed);
    endtask

    task automatic test_mul();
        int  n;
        bit  to;
        clearRom();
        rom[0] = mk(4'd3, 8'd1, 8'hFF, 8'hFD);
        rom[1] = mk(4'd3, 8'd2, 8'h00, 8'h07);
        rom[2] = mk(4'd7, 8'd5, 8'd1, 8'd2);
        rom[3] = mk(4'd6, 8'd0, 8'd5, 8'd0);
        rom[4] = mk(4'd6, 8'd0, 8'd6, 8'd0);
        rom[5] = mk(4'd3, 8'd3, 8'hFF, 8'hFF);
        rom[6] = mk(4'd8, 8'd7, 8'd3, 8'd3);
        rom[7] = mk(4'd6, 8'd0, 8'd7, 8'd0);
        rom[8] = mk(4'd6, 8'd0, 8'd8, 8'd0);
        rom[9] = mk(4'd5, 8'd9, 8'd0, 8'd0);
        doReset();
        waitBusy(n, to);
        total++;
        if (to || n != 17) begin
            bad++;
            $display("FAIL smul_busy_cycles: got %0d (timeout=%0d) required 17", n, to);
        end else $display("ok smul_busy_cycles busy=%0d", n);
        step(1);
        total++;
        if (oLed !== 16'hFFEB) begin
            bad++;
            $display("FAIL smul_low: got %h required ffeb", oLed);
        end else $display("ok smul_low led=%h", oLed);
        step(1);
        total++;
        if (oLed !== 16'hFFFF) begin
            bad++;
            $display("FAIL smul_high: got %h required ffff", oLed);
        end else $display("ok smul_high led=%h", oLed);
        waitBusy(n, to);
        total++;
        if (to || n != 17) begin
            bad++;
            $display("FAIL umul_busy_cycles: got %0d (timeout=%0d) required 17", n, to);
        end else $display("ok umul_busy_cycles busy=%0d", n);
        step(1);
        total++;
        if (oLed !== 16'h0001) begin
            bad++;
            $display("FAIL umul_low: got %h required 0001", oLed);
        end else $display("ok umul_low led=%h", oLed);
        step(1);
        total++;
        if (oLed !== 16'hFFFE) begin
            bad++;
            $display("FAIL umul_high: got %h required fffe", oLed);
        end else $display("ok umul_high led=%h", oLed);
    endtask

    task automatic test_reset_mid_mul();
        clearRom();
        rom[0] = mk(4'd3, 8'd1, 8'h00, 8'h02);
        rom[1] = mk(4'd3, 8'd2, 8'h00, 8'h03);
        rom[2] = mk(4'd8, 8'd5, 8'd1, 8'd2);
        rom[3] = mk(4'd5, 8'd3, 8'd0, 8'd0);
        doReset();
        step(11);
        total++;
        if (oBusy !== 1'b1) begin
            bad++;
            $display("FAIL midmul_busy_before: got %b required 1", oBusy);
        end else $display("ok midmul_busy_before busy=%b", oBusy);
        Reset = 1'b0;
        step(1);
        total++;
        if (oBusy !== 1'b0 || oIAddress !== 16'h0000) begin
            bad++;
            $display("FAIL midmul_abort: busy=%b addr=%h required 0 0000", oBusy, oIAddress);
        end else $display("ok midmul_abort busy=%b addr=%h", oBusy, oIAddress);
        clearRom();
        rom[0] = mk(4'd6, 8'd0, 8'd5, 8'd0);
        rom[1] = mk(4'd6, 8'd0, 8'd6, 8'd0);
        rom[2] = mk(4'd5, 8'd2, 8'd0, 8'd0);
        doReset();
        step(2);
        total++;
        if (oLed !== 16'hFFEB) begin
            bad++;
            $display("FAIL midmul_r5_kept: got %h required ffeb", oLed);
        end else $display("ok midmul_r5_kept led=%h", oLed);
        step(1);
        total++;
        if (oLed !== 16'hFFFF) begin
            bad++;
            $display("FAIL midmul_r6_kept: got %h required ffff", oLed);
        end else $display("ok midmul_r6_kept led=%h", oLed);
    endtask

    task automatic test_illegal();
        clearRom();
        rom[0] = mk(4'd3, 8'd1, 8'h00, 8'h55);
        rom[1] = mk(4'hC, 8'd1, 8'h12, 8'h34);
        rom[2] = mk(4'd6, 8'd0, 8'd1, 8'd0);
        rom[3] = mk(4'd5, 8'd3, 8'd0, 8'd0);
        doReset();
        step(1);
        total++;
        if (oIllegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_before: got %b required 0", oIllegal);
        end else $display("ok illegal_before ill=%b", oIllegal);
        step(1);
        total++;
        if (oIllegal !== 1'b1 || oIAddress !== 16'd2) begin
            bad++;
            $display("FAIL illegal_pulse: ill=%b addr=%h required 1 0002", oIllegal, oIAddress);
        end else $display("ok illegal_pulse ill=%b addr=%h", oIllegal, oIAddress);
        step(1);
        total++;
        if (oIllegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_after: got %b required 0", oIllegal);
        end else $display("ok illegal_after ill=%b", oIllegal);
        step(1);
        total++;
        if (oLed !== 16'h0055) begin
            bad++;
            $display("FAIL illegal_no_write: got %h required 0055", oLed);
        end else $display("ok illegal_no_write led=%h", oLed);
    endtask

    task automatic test_back_to_back();
        clearRom();
        rom[0] = mk(4'd3, 8'd1, 8'h00, 8'h01);
        rom[1] = mk(4'd1, 8'd1, 8'd1, 8'd1);
        rom[2] = mk(4'd1, 8'd1, 8'd1, 8'd1);
        rom[3] = mk(4'd1, 8'd1, 8'd1, 8'd1);
        rom[4] = mk(4'd6, 8'd0, 8'd1, 8'd0);
        rom[5] = mk(4'd5, 8'd5, 8'd0, 8'd0);
        doReset();
        step(6);
        total++;
        if (oLed !== 16'h0008) begin
            bad++;
            $display("FAIL back_to_back_bypass: got %h required 0008", oLed);
        end else $display("ok back_to_back_bypass led=%h", oLed);
    endtask

    task automatic test_wrap();
        clearRom();
        rom[0] = mk(4'd5, 8'd3, 8'd0, 8'd0);
        doReset();
        rom[0] = '0;
        step(1);
        rom[0] = mk(4'd5, 8'd3, 8'd0, 8'd0);
        step(65534);
        total++;
        if (oIAddress !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_at_top: got %h required ffff", oIAddress);
        end else $display("ok wrap_at_top addr=%h", oIAddress);
        step(1);
        total++;
        if (oIAddress !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_to_zero: got %h required 0000", oIAddress);
        end else $display("ok wrap_to_zero addr=%h", oIAddress);
        step(1);
        total++;
        if (oIAddress !== 16'h0003) begin
            bad++;
            $display("FAIL wrap_jmp_target: got %h required 0003", oIAddress);
        end else $display("ok wrap_jmp_target addr=%h", oIAddress);
        step(1);
        total++;
        if (oIAddress !== 16'h0004) begin
            bad++;
            $display("FAIL wrap_jmp_next: got %h required 0004", oIAddress);
        end else $display("ok wrap_jmp_next addr=%h", oIAddress);
    endtask

    initial begin
        Reset = 1'b0;
        test_reset();
        test_arith();
        test_branch();
        test_mul();
        test_reset_mid_mul();
        test_illegal();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
